cpu_dbg_ctrl: RTL and testbench

Run/halt/step controller and register-dump sequencer for the five-stage pipeline CPU.
- Drives a clock-enable to the pipeline.
- Stops the pipeline on a PC breakpoint or on an explicit command.
- Single-steps N enabled cycles.
- While halted, scans the 32 architectural registers through the CPU's regaddr/regdata debug port and streams them out over a valid/ready handshake.
- Sits between the board-level debug front end (UART/switches) and the cpu top.

---
 rtl/cpu_dbg_pkg.sv | 26 ++
 rtl/cpu_dbg_ctrl_dump.sv | 54 +++++
 rtl/cpu_dbg_ctrl.sv | 154 +++++++++++++++
 tb/tb_cpu_dbg_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug controller: command encodings,
// controller state enum and scan defaults.
package cpu_dbg_pkg;

  localparam logic [2:0] DBG_NOP  = 3'd0;
  localparam logic [2:0] DBG_RUN  = 3'd1;
  localparam logic [2:0] DBG_HALT = 3'd2;
  localparam logic [2:0] DBG_STEP = 3'd3;
  localparam logic [2:0] DBG_DUMP = 3'd4;

  localparam int NREGS_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_RUN,
    ST_STEP,
    ST_DUMP_ADDR,
    ST_DUMP_OUT
  } dbg_state_t;

  // States in which the pipeline is clocked.
  function automatic logic is_exec(dbg_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_dbg_ctrl_dump.sv
// Register-dump scanner: walks regaddr over the register file and presents
// one captured beat at a time on a valid/ready handshake.
module dbg_reg_dump #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] regdata,
  input  logic        dump_ready,
  output logic [4:0]  regaddr,
  output logic        dump_valid,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        beat,
  output logic        done
);

  localparam logic [4:0] LAST = 5'(NREGS - 1);

  logic busy;

  assign beat = dump_valid && dump_ready;
  assign done = beat && (dump_idx == LAST);

  // Alternates between an address/capture cycle and a hold-until-ready cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      regaddr    <= 5'd0;
      dump_valid <= 1'b0;
      dump_idx   <= 5'd0;
      dump_data  <= 32'd0;
    end else if (start) begin
      busy       <= 1'b1;
      regaddr    <= 5'd0;
      dump_valid <= 1'b0;
    end else if (busy) begin
      if (!dump_valid) begin
        dump_data  <= regdata;
        dump_idx   <= regaddr;
        dump_valid <= 1'b1;
      end else if (dump_ready) begin
        dump_valid <= 1'b0;
        if (dump_idx == LAST) begin
          busy <= 1'b0;
        end else begin
          regaddr <= regaddr + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/cpu_dbg_ctrl.sv
// Run/halt/step controller with PC breakpoint and register-dump sequencing
// for the pipeline CPU; drives the pipeline clock enable.
module cpu_dbg_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int RUN_ON_RESET = 1,
  parameter int STEP_W       = 16,
  parameter int NREGS        = NREGS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [STEP_W-1:0] step_cnt,
  input  logic [31:0]       pc,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  output logic              cpu_en,
  output logic              halted,
  output logic              bp_hit,
  output logic [4:0]        regaddr,
  input  logic [31:0]       regdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_idx,
  output logic [31:0]       dump_data,
  output logic [31:0]       en_cycles
);

  localparam dbg_state_t RESET_STATE = (RUN_ON_RESET != 0) ? ST_RUN : ST_HALT;
  localparam logic [STEP_W-1:0] ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  dbg_state_t        state, nxt;
  logic [STEP_W-1:0] cnt;
  logic              skip_bp;
  logic              cmd_fire, bp_match;
  logic              dump_start, dump_beat, dump_done;
  logic              load_cnt, set_bp, clr_bp, set_skip;

  assign cmd_fire = cmd_valid && cmd_ready;
  // skip_bp masks the match on the first enabled cycle after a resume.
  assign bp_match = bp_en && (pc == bp_addr) && !skip_bp;

  dbg_reg_dump #(.NREGS(NREGS)) u_dump (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (dump_start),
    .regdata    (regdata),
    .dump_ready (dump_ready),
    .regaddr    (regaddr),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .beat       (dump_beat),
    .done       (dump_done)
  );

  always_comb begin
    nxt        = state;
    dump_start = 1'b0;
    load_cnt   = 1'b0;
    set_bp     = 1'b0;
    clr_bp     = 1'b0;
    set_skip   = 1'b0;
    case (state)
      ST_HALT: begin
        if (cmd_fire) begin
          case (cmd_op)
            DBG_RUN: begin
              nxt      = ST_RUN;
              clr_bp   = 1'b1;
              set_skip = 1'b1;
            end
            DBG_STEP: begin
              nxt      = ST_STEP;
              load_cnt = 1'b1;
              clr_bp   = 1'b1;
              set_skip = 1'b1;
            end
            DBG_DUMP: begin
              nxt        = ST_DUMP_ADDR;
              dump_start = 1'b1;
            end
            default: nxt = ST_HALT;
          endcase
        end
      end
      ST_RUN: begin
        if (bp_match) begin
          nxt    = ST_HALT;
          set_bp = 1'b1;
        end else if (cmd_fire && (cmd_op == DBG_HALT)) begin
          nxt = ST_HALT;
        end
      end
      ST_STEP: begin
        if (bp_match) begin
          nxt    = ST_HALT;
          set_bp = 1'b1;
        end else if (cnt <= ONE) begin
          nxt = ST_HALT;
        end
      end
      ST_DUMP_ADDR: nxt = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (dump_done) begin
          nxt = ST_HALT;
        end else if (dump_beat) begin
          nxt = ST_DUMP_ADDR;
        end
      end
      default: nxt = ST_HALT;
    endcase
  end

  // Outputs are registered from the next state so they align with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_STATE;
      cpu_en    <= (RUN_ON_RESET != 0);
      halted    <= (RUN_ON_RESET == 0);
      cmd_ready <= 1'b1;
      cnt       <= '0;
      skip_bp   <= 1'b0;
      bp_hit    <= 1'b0;
      en_cycles <= 32'd0;
    end else begin
      state     <= nxt;
      cpu_en    <= is_exec(nxt);
      halted    <= (nxt == ST_HALT);
      cmd_ready <= (nxt == ST_HALT) || (nxt == ST_RUN);
      if (load_cnt) begin
        cnt <= (step_cnt == '0) ? ONE : step_cnt;
      end else if (state == ST_STEP) begin
        cnt <= cnt - ONE;
      end
      if (set_skip) begin
        skip_bp <= 1'b1;
      end else if (is_exec(state)) begin
        skip_bp <= 1'b0;
      end
      if (set_bp) begin
        bp_hit <= 1'b1;
      end else if (clr_bp) begin
        bp_hit <= 1'b0;
      end
      if (cpu_en) begin
        en_cycles <= en_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_dbg_ctrl.sv
// Self-checking bench for cpu_dbg_ctrl (halt-on-reset build) with a simple
// CPU stand-in: PC advances by 4 per enabled cycle, register file is an array.
module tb_cpu_dbg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] step_cnt = 16'd0;
  logic [31:0] pc;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic        cpu_en, halted, bp_hit;
  logic [4:0]  regaddr;
  logic [31:0] regdata;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic [31:0] en_cycles;

  logic [31:0] regfile [32];
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'd0;

  int errors = 0;
  int checks = 0;
  longint exp_en = 0;

  always #5 clk = ~clk;

  cpu_dbg_ctrl #(.RUN_ON_RESET(0), .STEP_W(16), .NREGS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .step_cnt   (step_cnt),
    .pc         (pc),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .regaddr    (regaddr),
    .regdata    (regdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .en_cycles  (en_cycles)
  );

  assign regdata = regfile[regaddr];

  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk);
    pc_load = 1'b1;
    pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [15:0] n);
    int t;
    @(negedge clk);
    cmd_op = op;
    step_cnt = n;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept op=%0d cmd_ready=%b required 1", op, cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int t;
    t = 0;
    while (halted !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_timeout halted=%b required 1 within %0d cycles", halted, budget);
    end
  endtask

  task automatic check_en(input string name);
    checks++;
    if (en_cycles !== exp_en[31:0]) begin
      errors++;
      $display("FAIL %s en_cycles=%0d required %0d", name, en_cycles, exp_en);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_en = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({cpu_en, halted, bp_hit, dump_valid, cmd_ready} !== 5'b01001) begin
      errors++;
      $display("FAIL reset_ctrl {cpu_en,halted,bp_hit,dump_valid,cmd_ready}=%b required 01001",
               {cpu_en, halted, bp_hit, dump_valid, cmd_ready});
    end
    checks++;
    if (regaddr !== 5'd0 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_dump regaddr=%0d dump_idx=%0d dump_data=%h required 0 0 0",
               regaddr, dump_idx, dump_data);
    end
    check_en("reset_en");
  endtask

  task automatic do_step(input logic [15:0] n);
    send_cmd(3'd3, n);
    wait_halt(n + 40);
    exp_en += (n == 0) ? 1 : n;
    check_en($sformatf("step_%0d", n));
    checks++;
    if (bp_hit !== 1'b0 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL step_flags n=%0d bp_hit=%b cpu_en=%b required 0 0", n, bp_hit, cpu_en);
    end
  endtask

  task automatic test_step();
    bp_en = 1'b0;
    do_step(16'd3);
    do_step(16'd0);
    for (int i = 0; i < 4; i++) do_step(16'($urandom_range(0, 20)));
  endtask

  task automatic test_breakpoint();
    int k;
    for (int it = 0; it < 3; it++) begin
      k = (it == 0) ? 4 : int'($urandom_range(1, 8));
      bp_en = 1'b1;
      bp_addr = 32'd4 * k;
      set_pc(32'd0);
      send_cmd(3'd1, 16'd0);
      wait_halt(60);
      exp_en += k + 1;
      check_en($sformatf("bp_run_k%0d", k));
      checks++;
      if (bp_hit !== 1'b1 || pc !== bp_addr + 32'd4) begin
        errors++;
        $display("FAIL bp_stop bp_hit=%b pc=%h required 1 %h", bp_hit, pc, bp_addr + 32'd4);
      end
      // Resume from the breakpoint PC: must not re-trigger there.
      set_pc(bp_addr);
      send_cmd(3'd1, 16'd0);
      repeat (6) @(negedge clk);
      checks++;
      if (halted !== 1'b0 || bp_hit !== 1'b0 || cpu_en !== 1'b1) begin
        errors++;
        $display("FAIL bp_resume halted=%b bp_hit=%b cpu_en=%b required 0 0 1",
                 halted, bp_hit, cpu_en);
      end
      send_cmd(3'd2, 16'd0);
      exp_en += 8;
      checks++;
      if (halted !== 1'b1 || cpu_en !== 1'b0) begin
        errors++;
        $display("FAIL halt_cmd halted=%b cpu_en=%b required 1 0", halted, cpu_en);
      end
      check_en("bp_resume_en");
    end
    // STEP 10 with the breakpoint reached on the 4th enabled cycle.
    bp_addr = 32'h0000_0100;
    set_pc(32'h0000_00F4);
    send_cmd(3'd3, 16'd10);
    wait_halt(40);
    exp_en += 4;
    check_en("step_bp_en");
    checks++;
    if (bp_hit !== 1'b1) begin
      errors++;
      $display("FAIL step_bp bp_hit=%b required 1", bp_hit);
    end
    bp_en = 1'b0;
  endtask

  task automatic run_dump(input bit pattern);
    int beats, cyc;
    bit held;
    logic [4:0] h_idx;
    logic [31:0] h_data;
    bit rdy;
    for (int i = 0; i < 32; i++) regfile[i] = pattern ? 32'h11 * i : $urandom;
    send_cmd(3'd4, 16'd0);
    cmd_op = 3'd1;
    cmd_valid = 1'b1;
    beats = 0;
    cyc = 0;
    held = 0;
    h_idx = 0;
    h_data = 0;
    while (beats < 32 && cyc < 400) begin
      cyc++;
      checks++;
      if (cmd_ready !== 1'b0 || cpu_en !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL dump_busy cmd_ready=%b cpu_en=%b halted=%b required 0 0 0",
                 cmd_ready, cpu_en, halted);
      end
      if (held) begin
        checks++;
        if (dump_valid !== 1'b1 || dump_idx !== h_idx || dump_data !== h_data) begin
          errors++;
          $display("FAIL dump_hold valid=%b idx=%0d data=%h required 1 %0d %h",
                   dump_valid, dump_idx, dump_data, h_idx, h_data);
        end
      end
      rdy = pattern ? bit'(cyc[0]) : bit'($urandom_range(0, 1));
      dump_ready = rdy;
      if (dump_valid === 1'b1) begin
        checks++;
        if (dump_idx !== 5'(beats) || dump_data !== regfile[beats]) begin
          errors++;
          $display("FAIL dump_beat idx=%0d data=%h required %0d %h",
                   dump_idx, dump_data, beats, regfile[beats]);
        end
        held = !rdy;
        h_idx = dump_idx;
        h_data = dump_data;
        if (rdy) begin
          beats++;
          if (beats == 32) cmd_valid = 1'b0;
        end
      end else begin
        held = 0;
      end
      @(negedge clk);
    end
    dump_ready = 1'b0;
    cmd_valid = 1'b0;
    checks++;
    if (beats != 32 || halted !== 1'b1 || dump_valid !== 1'b0 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL dump_end beats=%0d halted=%b dump_valid=%b cpu_en=%b required 32 1 0 0",
               beats, halted, dump_valid, cpu_en);
    end
    check_en("dump_en");
  endtask

  task automatic test_dump();
    run_dump(1'b1);
    run_dump(1'b0);
  endtask

  task automatic test_reset_mid();
    send_cmd(3'd3, 16'd1000);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cpu_en !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_step cpu_en=%b halted=%b required 0 1", cpu_en, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_en = 0;
    @(negedge clk);
    check_en("rst_mid_step_en");
    send_cmd(3'd4, 16'd0);
    dump_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (dump_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_dump_pre dump_valid=%b required 1", dump_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dump_valid !== 1'b0 || regaddr !== 5'd0 || dump_data !== 32'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_dump dump_valid=%b regaddr=%0d dump_data=%h cmd_ready=%b required 0 0 0 1",
               dump_valid, regaddr, dump_data, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || dump_valid !== 1'b0 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after halted=%b dump_valid=%b cpu_en=%b required 1 0 0",
               halted, dump_valid, cpu_en);
    end
    check_en("rst_mid_dump_en");
    do_step(16'd2);
  endtask

  initial begin
    pc = 32'd0;
    for (int i = 0; i < 32; i++) regfile[i] = 32'd0;
    test_reset();
    test_step();
    test_breakpoint();
    test_dump();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
